io_input_unit: RTL and testbench
================================

Name: io_input_unit

Overview:
Parametrised successor of the processor input stage. It provides:
- N synchronised, debounced push-buttons with level and one-shot outputs.
- A processor clock generator with fast-run, slow-run and single-step modes.
- A request/acknowledge handshake that captures switch or keyboard data for the IN instruction and freezes the processor clock while waiting.
It sits between the board I/O (buttons, switches, PS2 decoder) and the MIPS core.

Parameters:
NUM_BTN, 4, number of push-buttons (min 2; btn0 = step, btn1 = confirm)
DEB_BITS, 6, debounce counter width; a button is stable once the counter MSB sets (2^(DEB_BITS-1) cycles)
DATA_W, 14, input data width
CNT_W, 26, divider counter width
FAST_DIV, 1562500, Clock cycles per saidaClock half-period in fast-run mode
SLOW_DIV, 25000000, Clock cycles per saidaClock half-period in slow-run mode

Ports:
Clock  in  1  system clock, all logic on its rising edge
ResetN  in  1  asynchronous, active-low reset
Botao  in  NUM_BTN  raw buttons, active-low (0 = pressed)
Sw  in  DATA_W  raw switches
Mode  in  2  00 fast-run, 01 slow-run, 10 single-step, 11 = fast-run
key_data  in  DATA_W  PS2 decoder data
key_valid  in  1  PS2 decoder one-cycle strobe
InReq  in  1  level from core: IN instruction pending (sampled on Clock)
InAck  out  1  one-cycle strobe: resultadoEntrada valid
resultadoEntrada  out  DATA_W  captured input data, held until next capture
saidaBotao  out  NUM_BTN  debounced level, 1 = pressed
botaoPulse  out  NUM_BTN  one-cycle pulse on each debounced press
saidaClock  out  1  processor clock
Waiting  out  1  high while the FSM is in WAIT

Behaviour:
Reset (ResetN=0, asynchronous):
- All outputs 0. Counters 0. FSM IDLE. Synchronisers 0.

Debounce, per button:
- 2-FF synchroniser; input inverted so that 1 = pressed.
- Counter increments while pressed and the MSB is clear; saturates once the MSB sets.
- Counter clears in the cycle after the synchronised input shows released.
- saidaBotao = counter MSB.
- botaoPulse = 1 for exactly one cycle on the 0->1 edge of saidaBotao.
- Latency: 2 sync cycles + 2^(DEB_BITS-1) cycles press-to-level; pulse in the same cycle as the level.

Clock generator (divider counter `div`):
- Run modes, selected divisor D: `div` counts 0..D-1. At D-1, `div` returns to 0 and saidaClock toggles. Period = 2*D Clock cycles.
- Step mode:
  - A botaoPulse[0] in an idle step (saidaClock=0, no step active) starts a step: saidaClock=1 next cycle for FAST_DIV cycles, then 0. Exactly one rising edge per press.
  - Presses during an active step are ignored.
- Any Mode change: `div` clears, saidaClock forced 0 the next cycle.
- While Waiting=1: `div` and saidaClock hold. No toggle; step pulses are ignored.

Input FSM:
- IDLE: InReq=1 -> WAIT.
- WAIT, Waiting=1, completes on:
  - botaoPulse[1]: capture Sw.
  - key_valid: capture key_data (feature-dependent, see Optional Feature).
  - Both in the same cycle: key_data wins.
  - On completion: capture into resultadoEntrada -> DONE.
- DONE: InAck=1 for this single cycle -> HOLD.
- HOLD: waits for InReq=0 -> IDLE. A new request needs InReq low for at least 1 cycle.
- InReq falling while in WAIT (request withdrawn): -> IDLE, no capture, no InAck.
- Reset mid-WAIT: IDLE, resultadoEntrada=0, clock resumes from 0.

Optional Feature:
PS2_INPUT_EN:
- Defined: key_valid in WAIT completes the request with key_data, with priority over the confirm button.
- Undefined: key_data and key_valid are ignored (ports kept for a stable interface); only btn1 with Sw completes a request.

Decomposition:
- Package io_input_pkg:
  - Mode encodings MODE_FAST=2'b00, MODE_SLOW=2'b01, MODE_STEP=2'b10.
  - FSM state type: IDLE, WAIT, DONE, HOLD.
- Sub-module btn_debounce (parameter DEB_BITS): one instance per button via generate. Outputs level and pulse.

Test Plan:
All scenarios use NUM_BTN=2, DEB_BITS=3, FAST_DIV=4, SLOW_DIV=10.
1. Reset: hold ResetN=0 with Botao=2'b00 and Mode=00 -> every output 0. Release -> first saidaClock toggle exactly 4 cycles later, period 8 cycles.
2. Bounce: Botao[0] toggles every 2 cycles for 10 cycles, then holds 0 -> saidaBotao[0] rises 2+4 cycles after the stable hold, single botaoPulse[0]. Release -> level clears within 3 cycles.
3. Mode: switch 00->01 -> saidaClock forced 0, then period 20. Mode=10 with two btn0 presses -> exactly two high phases of 4 cycles each.
4. Switch input: InReq=1, Sw=14'h1A5 -> Waiting=1 and saidaClock frozen. btn1 press -> resultadoEntrada=14'h1A5, InAck pulse of exactly 1 cycle, clock resumes. InReq held high -> no second InAck.
5. Keyboard (PS2_INPUT_EN defined): InReq=1, key_valid and btn1 pulse in the same cycle with key_data=14'h0023 -> resultadoEntrada=14'h0023. Repeat with the macro undefined -> resultadoEntrada=Sw.
6. Abort/reset: InReq dropped in WAIT -> IDLE, no InAck, resultadoEntrada unchanged. ResetN pulse during WAIT -> all outputs 0, Waiting=0.

Source files
------------

// File: rtl/io_input_unit_pkg.sv
// Shared definitions for the io_input_unit slice: Mode encodings and input FSM states.
package io_input_pkg;

  localparam logic [1:0] MODE_FAST = 2'b00;
  localparam logic [1:0] MODE_SLOW = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10,
    HOLD = 2'b11
  } in_state_e;

  // Mode 2'b11 is an alias of fast-run, so everything except STEP free-runs.
  function automatic logic is_run_mode(input logic [1:0] mode);
    return mode != MODE_STEP;
  endfunction

endpackage

// File: rtl/io_input_unit_btn_debounce.sv
// One push-button: 2-FF synchroniser on the inverted raw input, saturating stability counter,
// level = counter MSB and a one-cycle pulse on its rising edge.
module btn_debounce #(
  parameter int DEB_BITS = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic pulse
);

  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic [DEB_BITS-1:0] cnt_q, cnt_d;
  logic                level_q, level_d;

  // Any released sample restarts the count; the MSB acts as the saturation stop.
  always_comb begin
    sync1_d = ~btn_n;
    sync2_d = sync1_q;
    level_d = cnt_q[DEB_BITS-1];
    cnt_d   = cnt_q;
    if (!sync2_q) begin
      cnt_d = '0;
    end else if (!cnt_q[DEB_BITS-1]) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = cnt_q[DEB_BITS-1];
  assign pulse = cnt_q[DEB_BITS-1] & ~level_q;

endmodule

// File: rtl/io_input_unit.sv
// Processor input stage: debounced buttons, run/step clock generator and IN request handshake.
// Define PS2_INPUT_EN to let a PS2 key strobe complete a pending request (priority over btn1).
module io_input_unit
  import io_input_pkg::*;
#(
  parameter int NUM_BTN  = 4,
  parameter int DEB_BITS = 6,
  parameter int DATA_W   = 14,
  parameter int CNT_W    = 26,
  parameter int FAST_DIV = 1562500,
  parameter int SLOW_DIV = 25000000
) (
  input  logic               Clock,
  input  logic               ResetN,
  input  logic [NUM_BTN-1:0] Botao,
  input  logic [DATA_W-1:0]  Sw,
  input  logic [1:0]         Mode,
  input  logic [DATA_W-1:0]  key_data,
  input  logic               key_valid,
  input  logic               InReq,
  output logic               InAck,
  output logic [DATA_W-1:0]  resultadoEntrada,
  output logic [NUM_BTN-1:0] saidaBotao,
  output logic [NUM_BTN-1:0] botaoPulse,
  output logic               saidaClock,
  output logic               Waiting
);

  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);
  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_DIV - 1);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEB_BITS (DEB_BITS)
    ) u_debounce (
      .clk   (Clock),
      .rst_n (ResetN),
      .btn_n (Botao[i]),
      .level (saidaBotao[i]),
      .pulse (botaoPulse[i])
    );
  end

  logic              key_hit;
  logic [DATA_W-1:0] key_word;

`ifdef PS2_INPUT_EN
  assign key_hit  = key_valid;
  assign key_word = key_data;
`else
  assign key_hit  = 1'b0;
  assign key_word = '0;
  logic unused_ps2;
  assign unused_ps2 = ^{key_data, key_valid};
`endif

  logic [CNT_W-1:0]  div_q, div_d;
  logic              clk_q, clk_d;
  logic              step_q, step_d;
  logic [1:0]        mode_q, mode_d;
  in_state_e         state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              in_ack_q, in_ack_d;
  logic              waiting_q, waiting_d;
  logic [CNT_W-1:0]  run_last;

  // A Mode change wins over the freeze so the new mode always starts from a clean low phase.
  always_comb begin
    div_d    = div_q;
    clk_d    = clk_q;
    step_d   = step_q;
    mode_d   = Mode;
    run_last = (Mode == MODE_SLOW) ? SLOW_LAST : FAST_LAST;
    if (Mode != mode_q) begin
      div_d  = '0;
      clk_d  = 1'b0;
      step_d = 1'b0;
    end else if (waiting_q) begin
      div_d = div_q;
    end else if (is_run_mode(Mode)) begin
      if (div_q == run_last) begin
        div_d = '0;
        clk_d = ~clk_q;
      end else begin
        div_d = div_q + 1'b1;
      end
    end else if (step_q) begin
      if (div_q == FAST_LAST) begin
        div_d  = '0;
        clk_d  = 1'b0;
        step_d = 1'b0;
      end else begin
        div_d = div_q + 1'b1;
      end
    end else if (botaoPulse[0] && !clk_q) begin
      div_d  = '0;
      clk_d  = 1'b1;
      step_d = 1'b1;
    end
  end

  // Withdrawal of InReq in WAIT takes priority over a same-cycle completion.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (InReq) state_d = WAIT;
      WAIT: begin
        if (!InReq) begin
          state_d = IDLE;
        end else if (key_hit) begin
          result_d = key_word;
          state_d  = DONE;
        end else if (botaoPulse[1]) begin
          result_d = Sw;
          state_d  = DONE;
        end
      end
      DONE:    state_d = HOLD;
      HOLD:    if (!InReq) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    waiting_d = (state_d == WAIT);
    in_ack_d  = (state_d == DONE);
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      div_q     <= '0;
      clk_q     <= 1'b0;
      step_q    <= 1'b0;
      mode_q    <= MODE_FAST;
      state_q   <= IDLE;
      result_q  <= '0;
      in_ack_q  <= 1'b0;
      waiting_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      clk_q     <= clk_d;
      step_q    <= step_d;
      mode_q    <= mode_d;
      state_q   <= state_d;
      result_q  <= result_d;
      in_ack_q  <= in_ack_d;
      waiting_q <= waiting_d;
    end
  end

  assign saidaClock       = clk_q;
  assign Waiting          = waiting_q;
  assign InAck            = in_ack_q;
  assign resultadoEntrada = result_q;

endmodule

// File: tb/tb_io_input_unit.sv
// Self-checking bench for io_input_unit: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_io_input_unit;

  localparam int NB  = 2;
  localparam int DB  = 3;
  localparam int DW  = 14;
  localparam int CW  = 26;
  localparam int FD  = 4;
  localparam int SD  = 10;
  localparam int WIN = 1 << (DB - 1);
`ifdef PS2_INPUT_EN
  localparam bit            PS2    = 1'b1;
  localparam logic [DW-1:0] KB_EXP = 14'h0023;
`else
  localparam bit            PS2    = 1'b0;
  localparam logic [DW-1:0] KB_EXP = 14'h0155;
`endif

  logic          Clock = 1'b0;
  logic          ResetN;
  logic [NB-1:0] Botao;
  logic [DW-1:0] Sw, key_data;
  logic [1:0]    Mode;
  logic          key_valid, InReq;
  logic          InAck, saidaClock, Waiting;
  logic [DW-1:0] resultadoEntrada;
  logic [NB-1:0] saidaBotao, botaoPulse;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 Clock = ~Clock;

  io_input_unit #(
    .NUM_BTN (NB), .DEB_BITS (DB), .DATA_W (DW),
    .CNT_W (CW), .FAST_DIV (FD), .SLOW_DIV (SD)
  ) dut (
    .Clock (Clock), .ResetN (ResetN), .Botao (Botao), .Sw (Sw), .Mode (Mode),
    .key_data (key_data), .key_valid (key_valid), .InReq (InReq), .InAck (InAck),
    .resultadoEntrada (resultadoEntrada), .saidaBotao (saidaBotao),
    .botaoPulse (botaoPulse), .saidaClock (saidaClock), .Waiting (Waiting)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NB-1:0] b, input logic [DW-1:0] s, input logic [1:0] m,
                               input logic req, input logic kv, input logic [DW-1:0] kd);
    Botao = b; Sw = s; Mode = m; InReq = req; key_valid = kv; key_data = kd;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clock);
      #2;
    end
  endtask

  task automatic cyclesUntilClk(input logic level, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (saidaClock !== level && n < 50);
  endtask

  // Model: a button is stable once its synchronised samples show WIN consecutive presses; the run
  // clock is (unfrozen cycles since the last Mode change / D) mod 2; a step lasts FD cycles.
  logic [15:0]   hist [NB];
  logic [NB-1:0] m_level, m_pulse;
  int            ticks, step_left, rq;
  logic [1:0]    prev_mode;
  logic          m_wait, m_ack, m_clk;
  logic [DW-1:0] m_res;

  always @(posedge Clock or negedge ResetN) begin : model
    logic [NB-1:0] old_pulse;
    logic          old_wait, lvl;
    if (!ResetN) begin
      for (int b = 0; b < NB; b++) hist[b] = '0;
      m_level = '0; m_pulse = '0; ticks = 0; step_left = 0; prev_mode = 2'b00;
      rq = 0; m_wait = 1'b0; m_ack = 1'b0; m_res = '0; m_clk = 1'b0;
    end else begin
      old_pulse = m_pulse;
      old_wait  = m_wait;
      case (rq)
        0: if (InReq) rq = 1;
        1: begin
          if (!InReq) rq = 0;
          else if (PS2 && key_valid) begin m_res = key_data; rq = 2; end
          else if (old_pulse[1]) begin m_res = Sw; rq = 2; end
        end
        2: rq = 3;
        default: if (!InReq) rq = 0;
      endcase
      m_wait = (rq == 1);
      m_ack  = (rq == 2);
      if (Mode !== prev_mode) begin
        ticks = 0; step_left = 0;
      end else if (!old_wait) begin
        if (Mode == 2'b10) begin
          if (step_left > 0) step_left--;
          else if (old_pulse[0]) step_left = FD;
        end else ticks++;
      end
      m_clk = (Mode == 2'b10) ? (step_left > 0) : (((ticks / ((Mode == 2'b01) ? SD : FD)) % 2) == 1);
      prev_mode = Mode;
      for (int b = 0; b < NB; b++) begin
        hist[b] = {hist[b][14:0], ~Botao[b]};
        lvl = 1'b1;
        for (int k = 2; k < 2 + WIN; k++) lvl &= hist[b][k];
        m_pulse[b] = lvl & ~m_level[b];
        m_level[b] = lvl;
      end
    end
  end

  always @(negedge Clock) begin
    checkOutput("saidaClock", saidaClock, m_clk);
    checkOutput("Waiting", Waiting, m_wait);
    checkOutput("InAck", InAck, m_ack);
    checkOutput("resultadoEntrada", resultadoEntrada, m_res);
    checkOutput("saidaBotao", saidaBotao, m_level);
    checkOutput("botaoPulse", botaoPulse, m_pulse);
  end

  initial begin
    int n, pulses, rises, highs, run, maxrun, toggles, acks;
    logic prev;
    logic [NB-1:0] b;
    logic [1:0] m;
    logic r;

    applyStimulus(2'b00, '0, 2'b00, 1'b0, 1'b0, '0);
    ResetN = 1'b0;
    step(3);
    checkOutput("rst_clk", saidaClock, 0);
    checkOutput("rst_wait", Waiting, 0);
    checkOutput("rst_ack", InAck, 0);
    checkOutput("rst_result", resultadoEntrada, 0);
    checkOutput("rst_level", saidaBotao, 0);
    checkOutput("rst_pulse", botaoPulse, 0);
    ResetN = 1'b1;
    cyclesUntilClk(1'b1, n); checkOutput("first_toggle", n, 4);
    cyclesUntilClk(1'b0, n); checkOutput("fast_high_phase", n, 4);
    cyclesUntilClk(1'b1, n); checkOutput("fast_low_phase", n, 4);
    Botao = 2'b11;
    step(6);

    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      Botao[0] = ((i / 2) % 2 == 0);
      step(1);
      pulses += int'(botaoPulse[0]);
    end
    Botao[0] = 1'b0;
    n = 0;
    do begin
      step(1); n++; pulses += int'(botaoPulse[0]);
    end while (!saidaBotao[0] && n < 50);
    checkOutput("deb_latency", n, 6);
    for (int i = 0; i < 3; i++) begin
      step(1); pulses += int'(botaoPulse[0]);
    end
    checkOutput("deb_pulse_count", pulses, 1);
    Botao[0] = 1'b1;
    n = 0;
    do begin
      step(1); n++;
    end while (saidaBotao[0] && n < 50);
    checkOutput("deb_release", n, 3);

    Mode = 2'b01;
    step(1);
    checkOutput("mode_change_clk", saidaClock, 0);
    cyclesUntilClk(1'b1, n); checkOutput("slow_first_rise", n, 10);
    cyclesUntilClk(1'b0, n); checkOutput("slow_high_phase", n, 10);
    cyclesUntilClk(1'b1, n); checkOutput("slow_low_phase", n, 10);

    Mode = 2'b10;
    step(1);
    checkOutput("step_entry_clk", saidaClock, 0);
    rises = 0; highs = 0; run = 0; maxrun = 0; prev = 1'b0;
    for (int i = 0; i < 60; i++) begin
      Botao[0] = !((i >= 2 && i < 12) || (i >= 25 && i < 35));
      step(1);
      if (saidaClock) begin
        highs++; run++;
        if (run > maxrun) maxrun = run;
        if (!prev) rises++;
      end else run = 0;
      prev = saidaClock;
    end
    checkOutput("step_rises", rises, 2);
    checkOutput("step_high_cycles", highs, 8);
    checkOutput("step_phase_len", maxrun, 4);

    Mode = 2'b00;
    step(3);
    Sw = 14'h1A5; InReq = 1'b1;
    step(1);
    checkOutput("sw_wait_entry", Waiting, 1);
    prev = saidaClock; toggles = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (saidaClock !== prev) toggles++;
      prev = saidaClock;
    end
    checkOutput("frozen_toggles", toggles, 0);
    Botao[1] = 1'b0; acks = 0; toggles = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      acks += int'(InAck);
      if (saidaClock !== prev) toggles++;
      prev = saidaClock;
    end
    checkOutput("sw_ack_count", acks, 1);
    checkOutput("sw_result", resultadoEntrada, 14'h1A5);
    checkOutput("sw_wait_clear", Waiting, 0);
    checkOutput("clk_resumed", toggles > 0, 1);
    Botao[1] = 1'b1; InReq = 1'b0;
    step(6);

    Sw = 14'h0155; InReq = 1'b1; Botao[1] = 1'b0;
    step(6);
    checkOutput("kb_pulse_align", botaoPulse[1], 1);
    key_valid = 1'b1; key_data = 14'h0023;
    step(1);
    key_valid = 1'b0;
    checkOutput("kb_ack", InAck, 1);
    checkOutput("kb_result", resultadoEntrada, KB_EXP);
    Botao[1] = 1'b1; InReq = 1'b0;
    step(6);

    InReq = 1'b1;
    step(3);
    checkOutput("abort_wait", Waiting, 1);
    InReq = 1'b0;
    step(1);
    checkOutput("abort_idle", Waiting, 0);
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      step(1); acks += int'(InAck);
    end
    checkOutput("abort_no_ack", acks, 0);
    checkOutput("abort_result", resultadoEntrada, KB_EXP);
    InReq = 1'b1;
    step(2);
    ResetN = 1'b0;
    #1;
    checkOutput("rstw_wait", Waiting, 0);
    checkOutput("rstw_ack", InAck, 0);
    checkOutput("rstw_result", resultadoEntrada, 0);
    checkOutput("rstw_clk", saidaClock, 0);
    checkOutput("rstw_level", saidaBotao, 0);
    checkOutput("rstw_pulse", botaoPulse, 0);
    step(2);
    InReq = 1'b0; ResetN = 1'b1;
    step(4);

    for (int i = 0; i < 3000; i++) begin
      b = Botao;
      for (int k = 0; k < NB; k++) if ($urandom_range(0, 11) == 0) b[k] = ~b[k];
      m = Mode;
      if ($urandom_range(0, 149) == 0) m = 2'($urandom_range(0, 3));
      r = InReq;
      if ($urandom_range(0, 24) == 0) r = ~r;
      applyStimulus(b, DW'($urandom), m, r, ($urandom_range(0, 15) == 0), DW'($urandom));
      if ($urandom_range(0, 999) == 0) begin
        ResetN = 1'b0;
        step(1);
        ResetN = 1'b1;
      end
      step(1);
    end
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
